// File: rtl/shared_bus_session_ctrl.sv
// Four-requester session arbiter for a single shared valid/ready port.
// A winner owns the port until its last beat, a MAX_BEATS truncation or a stall timeout.
module shared_bus_session_ctrl #(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_an,
    input  logic [3:0]            req,
    input  logic [3:0]            m_valid,
    input  logic [4*DATA_W-1:0]   m_data,
    input  logic [3:0]            m_last,
    output logic [3:0]            m_ready,
    output logic                  s_valid,
    output logic [DATA_W-1:0]     s_data,
    output logic                  s_last,
    output logic [1:0]            s_src,
    input  logic                  s_ready,
    output logic [3:0]            grant,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int BCW = $clog2(MAX_BEATS) + 1;
    localparam int SCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     owner_q, owner_d;
    logic [3:0]     grant_q, grant_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           timeout_q, timeout_d;

    logic           found;
    logic [1:0]     pick;
    logic [1:0]     idx;
    logic           beat;

    // Rotating search: first set req bit starting at ptr and wrapping upward.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            grant_q     <= 4'd0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = XFER;
                    owner_d     = pick;
                    grant_d     = 4'b0001 << pick;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            XFER: begin
                if (beat) begin
                    beat_cnt_d  = beat_cnt_q + BCW'(1);
                    stall_cnt_d = '0;
                    if (s_last) begin
                        state_d = DONE;
                        grant_d = 4'd0;
                    end
                end else if (stall_cnt_q == SCW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive idle cycle: abort without another beat.
                    stall_cnt_d = stall_cnt_q + SCW'(1);
                    timeout_d   = 1'b1;
                    state_d     = DONE;
                    grant_d     = 4'd0;
                end else begin
                    stall_cnt_d = stall_cnt_q + SCW'(1);
                end
            end
            DONE: begin
                ptr_d   = owner_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        m_ready = 4'd0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        if (state_q == XFER) begin
            s_valid          = m_valid[owner_q];
            s_data           = m_data[owner_q*DATA_W +: DATA_W];
            s_last           = m_last[owner_q] | (beat_cnt_q == BCW'(MAX_BEATS - 1));
            m_ready[owner_q] = s_ready;
        end
    end

    assign beat        = s_valid & s_ready;
    assign s_src       = owner_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_shared_bus_session_ctrl.sv
// Directed bench for shared_bus_session_ctrl: scoreboard of expected shared-port beats
// plus per-step checks of grant, timeout and reset behaviour.
module tb_shared_bus_session_ctrl;

    localparam int DW = 16;
    localparam int MB = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_an;
    logic [3:0]    req;
    logic [3:0]    m_valid;
    logic [4*DW-1:0] m_data;
    logic [3:0]    m_last;
    logic [3:0]    m_ready;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [1:0]    s_src;
    logic          s_ready;
    logic [3:0]    grant;
    logic          busy;
    logic          timeout_err;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    s;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    beatCount = 0;

    shared_bus_session_ctrl #(.DATA_W(DW), .MAX_BEATS(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_an(rst_an), .req(req), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_src(s_src), .s_ready(s_ready), .grant(grant),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every accepted shared-port beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_an) begin
            checkOutput("nonOwnerReady", 32'(m_ready & ~grant), 32'd0);
            if (s_valid && s_ready) begin
                beatCount++;
                checkOutput("beatExpected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    checkOutput("sData", 32'(s_data), 32'(e.d));
                    checkOutput("sLast", 32'(s_last), 32'(e.l));
                    checkOutput("sSrc", 32'(s_src), 32'(e.s));
                end
            end
        end
    end

    task automatic waitGrant(input logic [3:0] expGrant, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (grant == 4'd0 && cycles < 20);
        checkOutput("grant", 32'(grant), 32'(expGrant));
    endtask

    // Owner w offers n beats; the model stops after the beat it expects to carry s_last.
    task automatic applyStimulus(input int w, input int n, input bit withLast, input bit toggle);
        int k = 0;
        int cyc = 0;
        bit expLast;
        logic [DW-1:0] d;
        while (k < n && cyc < 200) begin
            s_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            d = DW'(16'h1000 + w * 256 + k);
            m_valid[w] = 1'b1;
            m_data[w*DW +: DW] = d;
            m_last[w] = withLast && (k == n - 1);
            expLast = (withLast && (k == n - 1)) || (k == MB - 1);
            if (s_ready) sb.push_back('{d: d, l: expLast, s: 2'(w)});
            @(posedge clk); #1;
            cyc++;
            if (s_ready) begin
                k++;
                if (expLast) break;
            end
        end
        m_valid[w] = 1'b0;
        m_last[w] = 1'b0;
        s_ready = 1'b1;
    endtask

    task automatic doneCheck(input string tag);
        checkOutput({tag, "DoneGrant"}, 32'(grant), 32'd0);
        checkOutput({tag, "DoneBusy"}, 32'(busy), 32'd1);
        checkOutput({tag, "DoneSvalid"}, 32'(s_valid), 32'd0);
        checkOutput({tag, "DoneTimeout"}, 32'(timeout_err), 32'd0);
        checkOutput({tag, "SbEmpty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int startBeats;
        logic [3:0] rr;
        rst_an = 1'b0;
        req = 4'd0;
        m_valid = 4'd0;
        m_data = '0;
        m_last = 4'd0;
        s_ready = 1'b1;
        #1;
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstSvalid", 32'(s_valid), 32'd0);
        checkOutput("rstMready", 32'(m_ready), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstTimeout", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        rst_an = 1'b1;
        @(posedge clk); #1;

        $display("[TB] round robin with all requests held");
        req = 4'b1111;
        rr = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            waitGrant(rr, cyc);
            checkOutput("rrLatency", 32'(cyc), (s == 0) ? 32'd1 : 32'd2);
            applyStimulus($clog2(rr), 1, 1'b1, 1'b0);
            doneCheck("rr");
            rr = {rr[2:0], rr[3]};
        end
        req = 4'd0;

        $display("[TB] truncation at MAX_BEATS");
        req = 4'b0100;
        waitGrant(4'b0100, cyc);
        startBeats = beatCount;
        applyStimulus(2, 20, 1'b0, 1'b0);
        doneCheck("trunc");
        checkOutput("truncBeats", 32'(beatCount - startBeats), 32'd16);

        $display("[TB] pointer after truncation and stall timeout");
        req = 4'b1111;
        waitGrant(4'b1000, cyc);
        for (int i = 0; i < TO - 1; i++) begin
            @(posedge clk); #1;
            checkOutput("stallNoTimeout", 32'(timeout_err), 32'd0);
            checkOutput("stallGrant", 32'(grant), 32'b1000);
        end
        @(posedge clk); #1;
        checkOutput("timeoutPulse", 32'(timeout_err), 32'd1);
        checkOutput("timeoutGrant", 32'(grant), 32'd0);
        checkOutput("timeoutBusy", 32'(busy), 32'd1);
        req = 4'd0;
        @(posedge clk); #1;
        checkOutput("timeoutOneCycle", 32'(timeout_err), 32'd0);
        checkOutput("timeoutIdleBusy", 32'(busy), 32'd0);

        $display("[TB] ready toggling with busy non-owners");
        m_valid = 4'b1101;
        m_data = {DW'(16'hDEAD), DW'(16'hBEEF), DW'(16'h0000), DW'(16'hCAFE)};
        req = 4'b0010;
        waitGrant(4'b0010, cyc);
        startBeats = beatCount;
        applyStimulus(1, 3, 1'b1, 1'b1);
        doneCheck("toggle");
        checkOutput("toggleBeats", 32'(beatCount - startBeats), 32'd3);
        m_valid = 4'd0;
        req = 4'd0;

        $display("[TB] request dropped after grant");
        req = 4'b0010;
        waitGrant(4'b0010, cyc);
        req = 4'd0;
        applyStimulus(1, 2, 1'b1, 1'b0);
        doneCheck("drop");

        $display("[TB] asynchronous reset mid-session");
        req = 4'b0100;
        waitGrant(4'b0100, cyc);
        s_ready = 1'b0;
        m_valid[2] = 1'b1;
        @(posedge clk); #1;
        #2 rst_an = 1'b0;
        #1;
        checkOutput("asyncGrant", 32'(grant), 32'd0);
        checkOutput("asyncSvalid", 32'(s_valid), 32'd0);
        checkOutput("asyncMready", 32'(m_ready), 32'd0);
        checkOutput("asyncBusy", 32'(busy), 32'd0);
        checkOutput("asyncTimeout", 32'(timeout_err), 32'd0);
        #3;
        m_valid = 4'd0;
        s_ready = 1'b1;
        req = 4'b1010;
        rst_an = 1'b1;
        waitGrant(4'b0010, cyc);
        req = 4'd0;
        applyStimulus(1, 1, 1'b1, 1'b0);
        doneCheck("postRst");
        @(posedge clk); #1;
        checkOutput("finalIdleBusy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/shared_bus_session_ctrl.md
SHARED_BUS_SESSION_CTRL -- requirements
Module: shared_bus_session_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the data width per requester and on the shared port.
REQ-002 The block SHALL have parameter MAX_BEATS, default 16, range 2..256, the maximum beats per session.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, range 1..65535, the number of stalled cycles before a session aborts.
REQ-004 The block SHALL have port clk, input, 1, the clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_an, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port req, input, 4, the per-requester session request.
REQ-007 The block SHALL have port m_valid, input, 4, the per-requester beat valid.
REQ-008 The block SHALL have port m_data, input, 4*DATA_W, the per-requester beat data; requester i uses bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port m_last, input, 4, the per-requester last-beat flag.
REQ-010 The block SHALL have port m_ready, output, 4, the per-requester beat accept.
REQ-011 The block SHALL have port s_valid, output, 1, the shared-port beat valid.
REQ-012 The block SHALL have port s_data, output, DATA_W, the shared-port beat data.
REQ-013 The block SHALL have port s_last, output, 1, the shared-port last beat.
REQ-014 The block SHALL have port s_src, output, 2, the index of the current owner.
REQ-015 The block SHALL have port s_ready, input, 1, the shared-port accept.
REQ-016 The block SHALL have port grant, output, 4, the one-hot owner, registered.
REQ-017 The block SHALL have port busy, output, 1, which is high in ARB_WAIT-free states XFER and DONE.
REQ-018 The block SHALL have port timeout_err, output, 1, a one-cycle pulse on session abort.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, XFER, DONE.
REQ-020 In IDLE with req!=0, the block SHALL select the first set req bit searching from rotate pointer ptr upward modulo 4, register grant as one-hot, and enter XFER on the next edge (one-cycle request-to-grant latency).
REQ-021 In IDLE, grant SHALL be 0, m_ready SHALL be 0, and s_valid SHALL be 0.
REQ-022 In XFER with owner w, outputs SHALL be combinational: s_valid=m_valid[w], s_data=m_data[w], m_ready[w]=s_ready, m_ready of every other requester SHALL be 0, and s_src=w.
REQ-023 A beat SHALL be s_valid&s_ready; beat_cnt (width clog2(MAX_BEATS)+1) SHALL increment per beat and clear on entry to XFER.
REQ-024 The block SHALL drive s_last=m_last[w] | (beat_cnt==MAX_BEATS-1), which forces truncation at MAX_BEATS.
REQ-025 A beat with s_last=1 SHALL end the session: the FSM enters DONE on the next edge.
REQ-026 stall_cnt SHALL count consecutive XFER cycles with no beat, clearing on any beat or XFER entry.
REQ-027 When stall_cnt reaches TIMEOUT, the block SHALL pulse timeout_err for exactly one cycle and enter DONE without further beats.
REQ-028 Deassertion of req[w] during XFER SHALL be ignored; the session continues until last, truncation or timeout.
REQ-029 In DONE (one cycle), grant, m_ready and s_valid SHALL be 0, ptr SHALL become (w+1) mod 4 for every termination cause, and the FSM SHALL return to IDLE.
REQ-030 Back-to-back sessions SHALL therefore have a minimum 2-cycle gap (DONE, IDLE) between the last beat and the next grant.
REQ-031 Requests arriving in the same cycle SHALL be resolved only by the ptr-relative search; no requester SHALL be granted twice while another holds req continuously.

Reset
REQ-032 On assertion of rst_an=0, regardless of state, the block SHALL immediately set state=IDLE, ptr=0, grant=0, beat_cnt=0, stall_cnt=0 and timeout_err=0.
REQ-033 While the FSM is in IDLE after reset, m_ready, s_valid and busy SHALL be 0.
REQ-034 Any session in progress SHALL be dropped without a timeout_err pulse.

Verification
REQ-035 Verification SHALL cover: req=4'b1111 held, each requester sending 1-beat sessions -> grant sequence 0001,0010,0100,1000,0001.
REQ-036 Verification SHALL cover: requester 2 streams 20 beats with m_last never set, MAX_BEATS=16 -> s_last on beat 16, session ends, ptr=3.
REQ-037 Verification SHALL cover: owner holds m_valid=0 for TIMEOUT=4 cycles -> timeout_err pulses once at the 4th stalled cycle, then DONE, grant=0.
REQ-038 Verification SHALL cover: s_ready toggling 1010 during a 3-beat session -> exactly 3 beats transferred, data in order, m_ready to non-owners stays 0.
REQ-039 Verification SHALL cover: rst_an pulsed low mid-XFER -> grant=0 and s_valid=0 with no clock edge required, and the first post-reset grant goes to the lowest set req bit (ptr=0).
REQ-040 Verification SHALL cover: req[1] deasserted after grant -> the session still completes on m_last[1].
